// File: rtl/regfile_mp.sv
// Dual-write register file: zero register, write-to-read bypass, busy scoreboard. Trace option: REGFILE_TRACE_EN.
// Latency: reads are combinational; writes and busy updates commit on the rising clk edge.
// Backpressure: none; writes and allocs are accepted every cycle.
module regfile_mp #(
  parameter int N = 32,
  parameter int L = 32,
  localparam int AW = $clog2(L)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_a,
  input  logic [AW-1:0] wa_a,
  input  logic [N-1:0]  wd_a,
  input  logic          we_b,
  input  logic [AW-1:0] wa_b,
  input  logic [N-1:0]  wd_b,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [N-1:0]  rd1,
  output logic [N-1:0]  rd2,
  output logic          busy1,
  output logic          busy2,
  input  logic          alloc_en,
  input  logic [AW-1:0] alloc_a,
  input  logic [AW-1:0] checka,
  output logic [N-1:0]  check
);

  logic [N-1:0] rf [L];
  logic [L-1:0] busy;
  logic [L-1:0] busy_nxt;

  // A new producer supersedes one completing in the same cycle, so set follows clear.
  always_comb begin
    busy_nxt = busy;
    if (we_a) busy_nxt[wa_a] = 1'b0;
    if (we_b) busy_nxt[wa_b] = 1'b0;
    if (alloc_en) busy_nxt[alloc_a] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < L; i++) rf[i] <= '0;
      busy <= '0;
    end else begin
      if (we_a && wa_a != '0) rf[wa_a] <= wd_a;
      if (we_b && wa_b != '0) rf[wa_b] <= wd_b;
      busy <= busy_nxt;
    end
  end

  // Port B outranks port A, matching which write the array keeps on a collision.
  function automatic logic [N-1:0] rd_sel(input logic [AW-1:0] ra);
    if (ra == '0)                     return '0;
    else if (rst_n && we_b && wa_b == ra) return wd_b;
    else if (rst_n && we_a && wa_a == ra) return wd_a;
    else                              return rf[ra];
  endfunction

  assign rd1   = rd_sel(ra1);
  assign rd2   = rd_sel(ra2);
  assign busy1 = busy[ra1];
  assign busy2 = busy[ra2];
  assign check = (checka == '0) ? '0 : rf[checka];

`ifdef REGFILE_TRACE_EN
  always @(posedge clk) begin
    if (rst_n) begin
      if (we_a && wa_a != '0 && !(we_b && wa_b == wa_a)) $display("REG%0d=%0d", wa_a, wd_a);
      if (we_b && wa_b != '0) $display("REG%0d=%0d", wa_b, wd_b);
    end
  end
`else
  // Default build carries no trace logic.
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: 32x32 instance for functional steps, 16x64 instance for the sweep.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 32 x 32 instance
  logic        we_a, we_b, alloc_en;
  logic [4:0]  wa_a, wa_b, ra1, ra2, alloc_a, checka;
  logic [31:0] wd_a, wd_b, rd1, rd2, check;
  logic        busy1, busy2;

  // 16 x 64 instance
  logic        s_we_a, s_we_b, s_alloc_en;
  logic [3:0]  s_wa_a, s_wa_b, s_ra1, s_ra2, s_alloc_a, s_checka;
  logic [63:0] s_wd_a, s_wd_b, s_rd1, s_rd2, s_check;
  logic        s_busy1, s_busy2;

  regfile_mp #(.N(32), .L(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2),
    .alloc_en(alloc_en), .alloc_a(alloc_a),
    .checka(checka), .check(check)
  );

  regfile_mp #(.N(64), .L(16)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .we_a(s_we_a), .wa_a(s_wa_a), .wd_a(s_wd_a),
    .we_b(s_we_b), .wa_b(s_wa_b), .wd_b(s_wd_b),
    .ra1(s_ra1), .ra2(s_ra2), .rd1(s_rd1), .rd2(s_rd2),
    .busy1(s_busy1), .busy2(s_busy2),
    .alloc_en(s_alloc_en), .alloc_a(s_alloc_a),
    .checka(s_checka), .check(s_check)
  );

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic push(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic cmp(input logic [63:0] obs);
    exp_t e;
    nvec++;
    if (sb.size() == 0) begin
      nerr++;
      $display("FAIL scoreboard_empty: observed %0h with no expected value", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        nerr++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  // Inputs change 2 time units after the rising edge, outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    we_a = 0; we_b = 0; alloc_en = 0;
    s_we_a = 0; s_we_b = 0; s_alloc_en = 0;
  endtask

  initial begin
    rst_n = 0;
    we_a = 0; wa_a = 0; wd_a = 0; we_b = 0; wa_b = 0; wd_b = 0;
    ra1 = 0; ra2 = 0; alloc_en = 0; alloc_a = 0; checka = 0;
    s_we_a = 0; s_wa_a = 0; s_wd_a = 0; s_we_b = 0; s_wa_b = 0; s_wd_b = 0;
    s_ra1 = 0; s_ra2 = 0; s_alloc_en = 0; s_alloc_a = 0; s_checka = 0;

    // Reset state, with write and alloc attempted while reset is held
    we_a = 1; wa_a = 4; wd_a = 32'h55; alloc_en = 1; alloc_a = 4;
    ra1 = 4; ra2 = 0; checka = 4;
    push("rst_rd1", 0); push("rst_rd2", 0); push("rst_busy1", 0); push("rst_check", 0);
    #1;
    cmp(rd1); cmp(rd2); cmp(busy1); cmp(check);
    step();
    push("rst_wr_ignored", 0); push("rst_alloc_ignored", 0);
    #1;
    cmp(check); cmp(busy1);
    idle();
    rst_n = 1;

    // Write 0x1234 to reg 5 while allocating it, then reset mid-operation
    step();
    we_a = 1; wa_a = 5; wd_a = 32'h1234; alloc_en = 1; alloc_a = 5;
    step();
    idle(); checka = 5; ra1 = 5;
    push("pre_rst_check5", 32'h1234); push("pre_rst_busy5", 1);
    #1;
    cmp(check); cmp(busy1);
    rst_n = 0;
    push("midrst_check5", 0); push("midrst_busy5", 0); push("midrst_rd1", 0);
    #1;
    cmp(check); cmp(busy1); cmp(rd1);
    we_b = 1; wa_b = 5; wd_b = 32'h777;
    step();
    idle();
    push("midrst_wr_ignored", 0);
    #1;
    cmp(check);
    rst_n = 1;

    // Bypass: old value 0x100 in reg 7, then overwrite with 0xDEAD
    step();
    we_a = 1; wa_a = 7; wd_a = 32'h100;
    step();
    we_a = 1; wa_a = 7; wd_a = 32'hDEAD; ra1 = 7; checka = 7;
    we_b = 1; wa_b = 8; wd_b = 32'hBEEF; ra2 = 8;
    push("byp_rd1", 32'hDEAD); push("byp_check_old", 32'h100); push("byp_rd2_portb", 32'hBEEF);
    #1;
    cmp(rd1); cmp(check); cmp(rd2);
    step();
    idle();
    push("byp_check_new", 32'hDEAD); push("byp_rd1_stored", 32'hDEAD); push("byp_rd2_stored", 32'hBEEF);
    #1;
    cmp(check); cmp(rd1); cmp(rd2);

    // Dual-write collision on reg 3
    step();
    we_a = 1; wa_a = 3; wd_a = 32'h11; we_b = 1; wa_b = 3; wd_b = 32'h22; ra1 = 3; checka = 3;
    push("coll_rd1", 32'h22);
    #1;
    cmp(rd1);
    step();
    idle();
    push("coll_stored", 32'h22);
    #1;
    cmp(check);

    // Register 0 never written, never busy
    step();
    we_a = 1; wa_a = 0; wd_a = 32'hFFFF; alloc_en = 1; alloc_a = 0; ra1 = 0; checka = 0;
    push("r0_rd1", 0); push("r0_busy1", 0);
    #1;
    cmp(rd1); cmp(busy1);
    step();
    idle();
    push("r0_check", 0); push("r0_busy1_after", 0);
    #1;
    cmp(check); cmp(busy1);

    // Scoreboard on reg 9
    step();
    alloc_en = 1; alloc_a = 9; ra1 = 9; ra2 = 9;
    push("sb_no_same_cycle_set", 0);
    #1;
    cmp(busy1);
    step();
    idle();
    push("sb_set", 1); push("sb_set_busy2", 1);
    #1;
    cmp(busy1); cmp(busy2);
    we_a = 1; wa_a = 9; wd_a = 32'h99;
    push("sb_busy_during_write", 1); push("sb_rd1_bypass", 32'h99);
    #1;
    cmp(busy1); cmp(rd1);
    step();
    idle();
    push("sb_cleared", 0);
    #1;
    cmp(busy1);
    alloc_en = 1; alloc_a = 9; we_a = 1; wa_a = 9; wd_a = 32'h9A;
    step();
    idle();
    push("sb_set_wins", 1);
    #1;
    cmp(busy1);
    alloc_en = 1; alloc_a = 9;
    step();
    idle();
    push("sb_realloc_busy", 1);
    #1;
    cmp(busy1);
    we_b = 1; wa_b = 9; wd_b = 32'h9B;
    step();
    idle();
    push("sb_clear_portb", 0);
    #1;
    cmp(busy2);

    // Sweep on the 16 x 64 instance, alternating write ports
    for (int i = 0; i < 16; i++) begin
      step();
      s_we_a = 0; s_we_b = 0;
      if (i % 2 == 0) begin
        s_we_a = 1; s_wa_a = 4'(i); s_wd_a = 64'(i * 3);
      end else begin
        s_we_b = 1; s_wa_b = 4'(i); s_wd_b = 64'(i * 3);
      end
    end
    step();
    idle();
    for (int i = 0; i < 16; i++) begin
      s_checka = 4'(i); s_ra1 = 4'(i);
      push($sformatf("sweep_check%0d", i), (i == 0) ? 64'd0 : 64'(i * 3));
      push($sformatf("sweep_rd1_%0d", i), (i == 0) ? 64'd0 : 64'(i * 3));
      #1;
      cmp(s_check); cmp(s_rd1);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised successor of the core register file. It keeps the zero-register and debug check port, and adds:
- a second write port,
- posedge writes with internal write-to-read bypass,
- asynchronous reset of all architectural state,
- a per-register busy scoreboard for in-flight (multi-cycle) producers.

It sits in the datapath decode stage and feeds operand values plus hazard status to the pipeline control.

Parameters:
N, 32, data width in bits
L, 32, number of registers (power of two, >= 2)
AW, $clog2(L), address width (derived; not overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
we_a  input  1  write enable, port A
wa_a  input  AW  write address, port A
wd_a  input  N  write data, port A
we_b  input  1  write enable, port B (higher priority)
wa_b  input  AW  write address, port B
wd_b  input  N  write data, port B
ra1  input  AW  read address 1
ra2  input  AW  read address 2
rd1  output  N  read data 1 (combinational)
rd2  output  N  read data 2 (combinational)
busy1  output  1  scoreboard bit for ra1 (combinational)
busy2  output  1  scoreboard bit for ra2 (combinational)
alloc_en  input  1  mark register alloc_a busy (producer issued)
alloc_a  input  AW  register to mark busy
checka  input  AW  debug address
check  output  N  debug data: raw stored value, no bypass

Behaviour:
- Reset: rst_n low immediately clears all L entries and all busy bits to 0, independent of clk. While rst_n is low, writes and allocs are ignored. rd1/rd2/check read 0; busy1/busy2 read 0.
- Register 0: always reads 0, never busy. Writes and allocs to address 0 are dropped.
- Write: on posedge clk with rst_n high, rf[wa_x] <= wd_x for each enabled port.
  - we_a and we_b both set with wa_a == wa_b: port B's data is stored.
- Read with bypass (per read port, in priority order):
  1. ra == 0 -> 0.
  2. we_b && wa_b == ra -> wd_b.
  3. we_a && wa_a == ra -> wd_a.
  4. otherwise rf[ra].
  - Effective read latency from a write is zero: same-cycle bypass, stored value from the next cycle.
- check: returns rf[checka] with no bypass; checka == 0 returns 0.
- Scoreboard (one busy bit per register, updated on posedge clk):
  - Set: alloc_en && alloc_a != 0.
  - Clear: any enabled write port targets that register.
  - Same-cycle alloc and write to the same register: set wins (the new producer supersedes the completing one).
  - alloc to an already-busy register: stays busy.
- Busy outputs:
  - busy1 = busy[ra1], with no bypass of same-cycle set/clear.
  - A write landing this cycle still shows busy; rd1 already carries bypassed data.
  - Pipeline control qualifies busy with the bypass hit.
- No other sequential state. Outputs are fully combinational from state plus current-cycle inputs.

Optional Feature:
REGFILE_TRACE_EN
- Defined: on each committed write to a nonzero register, simulation prints "REG<addr>=<data>" in decimal, once per port. A same-address dual write prints only port B.
- Undefined: no display statements compiled. Functional behaviour is identical either way.

Test Plan:
1. Reset mid-operation: write rf[5]=0x1234, assert rst_n low between edges -> check(5)=0 immediately, busy all 0. Writes during reset are ignored.
2. Bypass: we_a=1, wa_a=7, wd_a=0xDEAD, ra1=7 -> rd1=0xDEAD same cycle, check(7)=old value. Next cycle check(7)=0xDEAD.
3. Dual-write collision: we_a/we_b both to reg 3, wd_a=0x11, wd_b=0x22 -> ra1=3 reads 0x22 same cycle; stored value 0x22.
4. Register 0: write 0xFFFF to reg 0 and alloc_a=0 -> rd1(ra1=0)=0, busy1=0, check(0)=0.
5. Scoreboard: alloc reg 9 -> busy1(ra1=9)=1 next cycle. Write reg 9 via port A -> busy1=0 following cycle. Alloc and write reg 9 in the same cycle -> busy remains 1.
6. Sweep: L=16, N=64 instance; write address i with value i*3 for all i -> check(i)=i*3 for i>0, check(0)=0.
